// File: rtl/fabric_spi_gpio_expander_if.sv
// Pad bus between the fabric user-design wrapper and the GPIO expander.
// The wrapper (or a bench) is the master and drives io_in; the design is
// the slave and drives io_out / io_oeb.
interface fabric_spi_gpio_expander_if #(
  parameter int NUM_IO = 48
);
  logic [NUM_IO-1:0] io_in;
  logic [NUM_IO-1:0] io_out;
  logic [NUM_IO-1:0] io_oeb;

  modport master (output io_in, input io_out, input io_oeb);
  modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/fabric_spi_gpio_expander.sv
// SPI (mode 0, MSB first, 16-bit frames) responder exposing io[47:8] as a
// register-mapped GPIO expander. The SPI pins are oversampled on clk; all
// logic lives in the single clk domain.
module fabric_spi_gpio_expander #(
  parameter int          NUM_IO   = 48,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  fabric_spi_gpio_expander_if.slave bus
);
  localparam int GPIO_W    = NUM_IO - 8;
  localparam int NUM_BYTES = GPIO_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Pads 7:3 are inputs we never look at.
  logic unused_pads;
  assign unused_pads = ^bus.io_in[7:3];

  logic [2:0]        sck_q;
  logic [1:0]        csn_q;
  logic [1:0]        mosi_q;
  logic [1:0]        fill_q;
  logic              seen_high_q;
  logic [GPIO_W-1:0] gin_meta_q;
  logic [GPIO_W-1:0] gin_q;

  // Synchronisers for the SPI pins and GPIO inputs; fill_q marks when the
  // CS_N chain holds a real pad sample rather than its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q       <= '0;
      csn_q       <= 2'b11;
      mosi_q      <= '0;
      fill_q      <= '0;
      seen_high_q <= 1'b0;
      gin_meta_q  <= '0;
      gin_q       <= '0;
    end else begin
      sck_q      <= {sck_q[1:0], bus.io_in[0]};
      csn_q      <= {csn_q[0], bus.io_in[1]};
      mosi_q     <= {mosi_q[0], bus.io_in[2]};
      fill_q     <= {fill_q[0], 1'b1};
      gin_meta_q <= bus.io_in[NUM_IO-1:8];
      gin_q      <= gin_meta_q;
      if (fill_q[1] && csn_q[1]) seen_high_q <= 1'b1;
    end
  end

  logic sck_rise, sck_fall, csn_sync, mosi_sync;
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign csn_sync  = csn_q[1];
  assign mosi_sync = mosi_q[1];

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] cmd_q, cmd_d;
  logic       miso_q, miso_d;
  logic       wr_pend_q, wr_pend_d;

  logic [GPIO_W-1:0] out_vec;
  logic [GPIO_W-1:0] oe_vec;

  // Per-byte OUT / OE registers; a pending write lands here one clk after
  // the 16th rise, leaving untouched bytes completely static.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : gen_byte
    localparam logic [6:0] OUT_ADDR = 7'(gi);
    localparam logic [6:0] OE_ADDR  = 7'(8 + gi);
    logic [7:0] out_byte_q;
    logic [7:0] oe_byte_q;
    // Commit a completed write frame to this byte if it is addressed.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_byte_q <= '0;
        oe_byte_q  <= '0;
      end else if (wr_pend_q) begin
        if (cmd_q[6:0] == OUT_ADDR) out_byte_q <= rx_q;
        if (cmd_q[6:0] == OE_ADDR)  oe_byte_q  <= rx_q;
      end
    end
    assign out_vec[gi*8 +: 8] = out_byte_q;
    assign oe_vec[gi*8 +: 8]  = oe_byte_q;
  end

  // Read data is selected from the command as it completes on the 8th rise.
  logic [7:0] cmd_new;
  logic [5:0] bsel;
  logic       byte_ok;
  logic [7:0] rd_byte;
  assign cmd_new = {rx_q[6:0], mosi_sync};
  assign bsel    = {cmd_new[2:0], 3'b000};
  assign byte_ok = (cmd_new[2:0] <= 3'd4);

  // Register-map read decode.
  always_comb begin
    rd_byte = 8'h00;
    if (cmd_new[6:0] == 7'h1F)                 rd_byte = ID_VALUE;
    else if (cmd_new[6:3] == 4'd0 && byte_ok)  rd_byte = out_vec[bsel +: 8];
    else if (cmd_new[6:3] == 4'd1 && byte_ok)  rd_byte = oe_vec[bsel +: 8];
    else if (cmd_new[6:3] == 4'd2 && byte_ok)  rd_byte = gin_q[bsel +: 8];
  end

  // Frame sequencer: command byte, data byte, then ignore SCK until CS_N
  // deasserts. CS_N going high before the data byte completes aborts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    miso_d    = miso_q;
    wr_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = 4'd0;
        if (!csn_sync && seen_high_q) state_d = ST_CMD;
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (csn_sync) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          rx_d  = cmd_new;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cmd_d   = cmd_new;
            tx_d    = cmd_new[7] ? rd_byte : 8'h00;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (csn_sync) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else if (sck_rise) begin
          rx_d  = cmd_new;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d   = ST_DONE;
            miso_d    = 1'b0;
            wr_pend_d = ~cmd_q[7];
          end
        end else if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      default: begin
        miso_d = 1'b0;
        if (csn_sync) state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      miso_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_q     <= cmd_d;
      miso_q    <= miso_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] gpio_oeb_q;

  // GPIO pad drivers, registered straight from the OUT / OE registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      gpio_oeb_q <= '1;
    end else begin
      gpio_out_q <= out_vec;
      gpio_oeb_q <= ~oe_vec;
    end
  end

  assign bus.io_out = {gpio_out_q, 4'b0000, miso_q, 3'b000};
  assign bus.io_oeb = {gpio_oeb_q, 4'b1111, csn_sync, 3'b111};
endmodule

// File: tb/tb_fabric_spi_gpio_expander.sv
// Randomised bench for the SPI GPIO expander: a stimulus process acts as
// SPI master and pushes expectations from a register-level model; a monitor
// snoops the pads, rebuilds each frame and compares against the queues.
module tb_fabric_spi_gpio_expander;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fabric_spi_gpio_expander_if #(.NUM_IO(48)) bus ();

  fabric_spi_gpio_expander #(.NUM_IO(48), .ID_VALUE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic        sck_pad, csn_pad, mosi_pad;
  logic [39:0] gin_pad;
  assign bus.io_in = {gin_pad, 5'b00000, mosi_pad, csn_pad, sck_pad};

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  out_m [5];
  logic [7:0]  oe_m  [5];
  logic [7:0]  rd_q  [$];
  logic [79:0] pad_q [$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_read(input logic [6:0] a);
    int k;
    k = int'(a) % 8;
    if (a == 7'h1F) return 8'hA5;
    if (a < 7'd5) return out_m[k];
    if (a >= 7'd8 && a < 7'd13) return oe_m[k];
    if (a >= 7'd16 && a < 7'd21) return gin_pad[k*8 +: 8];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    int k;
    k = int'(a) % 8;
    if (a < 7'd5) out_m[k] = d;
    else if (a >= 7'd8 && a < 7'd13) oe_m[k] = d;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      out_m[k] = 8'h00;
      oe_m[k]  = 8'h00;
    end
  endtask

  function automatic logic [79:0] model_pads();
    logic [39:0] o, e;
    for (int k = 0; k < 5; k++) begin
      o[k*8 +: 8] = out_m[k];
      e[k*8 +: 8] = ~oe_m[k];
    end
    return {o, e};
  endfunction

  // ---------------- SPI master ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                           input int nbits, input bit rst_mid);
    logic [23:0] sh;
    sh = {cmd, d0, d1};
    $display("frame rw=%0d addr=%02h d0=%02h d1=%02h bits=%0d rst=%0d",
             cmd[7], cmd[6:0], d0, d1, nbits, rst_mid);
    if (rst_mid) begin
      model_reset();
    end else if (nbits >= 16) begin
      if (cmd[7]) rd_q.push_back(model_read(cmd[6:0]));
      else        model_write(cmd[6:0], d0);
    end
    pad_q.push_back(model_pads());

    csn_pad = 1'b0;
    wait_clk($urandom_range(4, 6));
    for (int i = 0; i < nbits; i++) begin
      sck_pad  = 1'b0;
      mosi_pad = sh[23-i];
      wait_clk($urandom_range(4, 6));
      if (rst_mid && i == 8) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
      end
      sck_pad = 1'b1;
      wait_clk($urandom_range(4, 6));
    end
    sck_pad = 1'b0;
    wait_clk(5);
    csn_pad = 1'b1;
    wait_clk(16);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       psck, pcsn;
    logic [7:0] mcmd, mrd;
    logic       cm;
    int         nb;
    psck = 1'b0; pcsn = 1'b1; mcmd = '0; mrd = '0; cm = 1'b0; nb = 0;
    forever begin
      @(negedge clk);
      if (pcsn && !csn_pad) begin
        nb = 0; mcmd = '0; mrd = '0; cm = 1'b0;
      end
      if (!csn_pad && !psck && sck_pad) begin
        if (nb == 0) check("cs_miso_oe", 80'(bus.io_oeb[3]), 80'd0);
        if (nb < 8) begin
          mcmd = {mcmd[6:0], mosi_pad};
          cm   = cm | bus.io_out[3];
        end else if (nb < 16) begin
          mrd = {mrd[6:0], bus.io_out[3]};
        end
        nb++;
      end
      if (!pcsn && csn_pad) begin
        if (nb >= 16 && mcmd[7]) begin
          if (rd_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL read_unexpected: got %02h expected none", mrd);
          end else begin
            check("read_data", 80'(mrd), 80'(rd_q.pop_front()));
          end
          check("cmd_miso_zero", 80'(cm), 80'd0);
        end
        repeat (8) @(negedge clk);
        if (pad_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pads_unexpected: got frame end expected none");
        end else begin
          check("gpio_pads", {bus.io_out[47:8], bus.io_oeb[47:8]}, pad_q.pop_front());
        end
        check("miso_hiz_idle", 80'(bus.io_oeb[3]), 80'd1);
      end
      psck = sck_pad;
      pcsn = csn_pad;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] a;
    logic [7:0] d;
    int         n, r;
    rst = 1'b1; sck_pad = 1'b0; csn_pad = 1'b1; mosi_pad = 1'b0; gin_pad = '0;
    model_reset();
    wait_clk(2);
    check("reset_io_out", 80'(bus.io_out), 80'd0);
    check("reset_io_oeb", 80'(bus.io_oeb), 80'hFFFF_FFFF_FFFF);
    rst = 1'b0;
    wait_clk(10);
    check("idle_io_out", 80'(bus.io_out), 80'd0);
    check("idle_io_oeb", 80'(bus.io_oeb), 80'hFFFF_FFFF_FFFF);

    spi_frame(8'h08, 8'hFF, 8'h00, 16, 1'b0);
    spi_frame(8'h00, 8'h5A, 8'h00, 16, 1'b0);
    spi_frame(8'h9F, 8'h00, 8'h00, 16, 1'b0);
    gin_pad[15:8] = 8'hC3;
    wait_clk(6);
    spi_frame(8'h91, 8'h00, 8'h00, 16, 1'b0);
    spi_frame(8'h11, 8'hFF, 8'h00, 16, 1'b0);
    spi_frame(8'h04, 8'h77, 8'h00, 12, 1'b0);
    spi_frame(8'h84, 8'h00, 8'h00, 16, 1'b0);
    spi_frame(8'h01, 8'h3C, 8'hFF, 24, 1'b0);
    spi_frame(8'h81, 8'h00, 8'h00, 16, 1'b0);
    spi_frame(8'h02, 8'h00, 8'h66, 24, 1'b1);
    spi_frame(8'h80, 8'h00, 8'h00, 16, 1'b0);
    spi_frame(8'h02, 8'h99, 8'h00, 16, 1'b0);
    spi_frame(8'h82, 8'h00, 8'h00, 16, 1'b0);

    for (int it = 0; it < 48; it++) begin
      if (it % 4 == 0) begin
        gin_pad = {8'($urandom), 32'($urandom)};
        wait_clk(6);
      end
      a = 7'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(1, 15);
      else if (r == 1) n = $urandom_range(17, 24);
      else             n = 16;
      spi_frame({1'($urandom_range(0, 1)), a}, d, 8'($urandom), n, 1'b0);
    end

    wait_clk(30);
    check("read_queue_drained", 80'(rd_q.size()), 80'd0);
    check("pad_queue_drained", 80'(pad_q.size()), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
